// File: rtl/memdata_arbiter.sv
// memdata_arbiter: two-port arbiter in front of a single-port data memory.
// Each transaction takes three cycles: grant (IDLE->ACCESS), memory access
// (ACCESS->DONE) and completion (DONE->IDLE), with a one-cycle ack pulse to
// the granted port. Conflicts are resolved round-robin or fixed-priority (A).
module memdata_arbiter #(
   parameter int XLEN        = 32,
   parameter int ROUND_ROBIN = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_a,
   input  logic            req_b,
   input  logic            we_a,
   input  logic            we_b,
   input  logic [XLEN-1:0] addr_a,
   input  logic [XLEN-1:0] addr_b,
   input  logic [XLEN-1:0] wdata_a,
   input  logic [XLEN-1:0] wdata_b,
   output logic            ack_a,
   output logic            ack_b,
   output logic [XLEN-1:0] rdata_a,
   output logic [XLEN-1:0] rdata_b,
   output logic            busy,
   output logic [XLEN-1:0] mem_address,
   output logic [XLEN-1:0] mem_data,
   output logic            mem_write,
   input  logic [XLEN-1:0] mem_out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              last_b_q, last_b_d;      // 1 = last grant went to port B
   logic              gnt_b_q, gnt_b_d;        // port owning the transaction in flight
   logic              we_q, we_d;              // direction of the transaction in flight
   logic [XLEN-1:0]   mem_address_q, mem_address_d;
   logic [XLEN-1:0]   mem_data_q, mem_data_d;
   logic              mem_write_q, mem_write_d;
   logic              ack_a_q, ack_a_d;
   logic              ack_b_q, ack_b_d;
   logic [XLEN-1:0]   rdata_a_q, rdata_a_d;
   logic [XLEN-1:0]   rdata_b_q, rdata_b_d;
   logic              grant_b_s;

   // Arbitration: a lone request wins; a tie goes to the port not granted last
   // (round-robin) or always to port A (fixed priority).
   always_comb begin
      grant_b_s = 1'b0;
      if (req_a && req_b) begin
         if (ROUND_ROBIN != 0) begin
            grant_b_s = ~last_b_q;
         end else begin
            grant_b_s = 1'b0;
         end
      end else begin
         grant_b_s = req_b;
      end
   end

   // Next-state and output logic of the transaction FSM.
   always_comb begin
      state_d       = state_q;
      last_b_d      = last_b_q;
      gnt_b_d       = gnt_b_q;
      we_d          = we_q;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
      mem_write_d   = 1'b0;
      ack_a_d       = 1'b0;
      ack_b_d       = 1'b0;
      rdata_a_d     = rdata_a_q;
      rdata_b_d     = rdata_b_q;
      case (state_q)
         IDLE: begin
            if (req_a || req_b) begin
               state_d  = ACCESS;
               last_b_d = grant_b_s;
               gnt_b_d  = grant_b_s;
               if (grant_b_s) begin
                  mem_address_d = addr_b;
                  mem_data_d    = wdata_b;
                  mem_write_d   = we_b;
                  we_d          = we_b;
               end else begin
                  mem_address_d = addr_a;
                  mem_data_d    = wdata_a;
                  mem_write_d   = we_a;
                  we_d          = we_a;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            // Memory samples address/write on this edge; write strobe ends here.
            state_d = DONE;
         end
         DONE: begin
            // mem_out now reflects the address registered at the grant edge.
            state_d = IDLE;
            if (gnt_b_q) begin
               ack_b_d = 1'b1;
               if (!we_q) begin
                  rdata_b_d = mem_out;
               end else begin
                  rdata_b_d = rdata_b_q;
               end
            end else begin
               ack_a_d = 1'b1;
               if (!we_q) begin
                  rdata_a_d = mem_out;
               end else begin
                  rdata_a_d = rdata_a_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         last_b_q      <= 1'b1;
         gnt_b_q       <= 1'b0;
         we_q          <= 1'b0;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         mem_write_q   <= 1'b0;
         ack_a_q       <= 1'b0;
         ack_b_q       <= 1'b0;
         rdata_a_q     <= '0;
         rdata_b_q     <= '0;
      end else begin
         state_q       <= state_d;
         last_b_q      <= last_b_d;
         gnt_b_q       <= gnt_b_d;
         we_q          <= we_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         mem_write_q   <= mem_write_d;
         ack_a_q       <= ack_a_d;
         ack_b_q       <= ack_b_d;
         rdata_a_q     <= rdata_a_d;
         rdata_b_q     <= rdata_b_d;
      end
   end

   assign ack_a       = ack_a_q;
   assign ack_b       = ack_b_q;
   assign rdata_a     = rdata_a_q;
   assign rdata_b     = rdata_b_q;
   assign mem_address = mem_address_q;
   assign mem_data    = mem_data_q;
   assign mem_write   = mem_write_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: doc/memdata_arbiter.md
MEMDATA_ARBITER -- requirements
Module: memdata_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width in bits.
REQ-002 SHALL have parameter ROUND_ROBIN, default 1: 1 = alternate on conflict, 0 = port A always wins.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_a, req_b  input  1  transaction request, port A / port B.
REQ-006 we_a, we_b  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr_a, addr_b  input  XLEN  word address.
REQ-008 wdata_a, wdata_b  input  XLEN  write data.
REQ-009 ack_a, ack_b  output  1  one-cycle completion pulse per port.
REQ-010 rdata_a, rdata_b  output  XLEN  read data, valid while the matching ack is high.
REQ-011 busy  output  1  high while state is not IDLE.
REQ-012 mem_address  output  XLEN  address to the data memory.
REQ-013 mem_data  output  XLEN  write data to the data memory.
REQ-014 mem_write  output  1  write enable to the data memory.
REQ-015 mem_out  input  XLEN  memory read data, registered, valid one cycle after the address edge.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, DONE; transitions IDLE->ACCESS when any req is high at an edge, ACCESS->DONE unconditionally, DONE->IDLE unconditionally.
REQ-017 In IDLE at an edge with only one req high, SHALL grant that port.
REQ-018 In IDLE with both req high: ROUND_ROBIN=1 SHALL grant the port not in last_grant; ROUND_ROBIN=0 SHALL grant port A.
REQ-019 SHALL update last_grant to the granted port on every grant.
REQ-020 On the grant edge SHALL register mem_address<=addr_x, mem_data<=wdata_x, mem_write<=we_x, and record granted port and we_x internally.
REQ-021 On the ACCESS->DONE edge SHALL clear mem_write; mem_write SHALL be high for exactly the single ACCESS cycle of a write and never otherwise.
REQ-022 mem_address and mem_data SHALL hold their last registered value outside ACCESS.
REQ-023 On the DONE->IDLE edge SHALL set ack_x=1 for the granted port only, for exactly one cycle; for a read, rdata_x<=mem_out on the same edge.
REQ-024 rdata_x SHALL hold its value until that port's next completed read; writes SHALL NOT change rdata_x.
REQ-025 ack_a and ack_b SHALL never be high in the same cycle.
REQ-026 Latency: grant edge E0 -> ack high in the cycle after edge E2; peak throughput one transaction per 3 cycles.
REQ-027 Requesters hold req, we, addr, and wdata stable until ack; changes after the grant edge SHALL NOT affect the transaction in flight.
REQ-028 A req still high on the edge ending its ack cycle SHALL be treated as a new request and arbitrated normally.
REQ-029 A req raised while busy SHALL wait without loss until the next IDLE edge.
REQ-030 The non-granted port SHALL see no ack and no rdata change.

Reset
REQ-031 rst_n=0 at an edge SHALL force state=IDLE, mem_address=0, mem_data=0, mem_write=0, ack_a=ack_b=0, rdata_a=rdata_b=0, last_grant=B (port A wins the first tie); busy=0 follows.
REQ-032 Reset during ACCESS or DONE SHALL abandon the transaction; no ack is produced, and the transaction is not retried.

Verification
REQ-033 Write A: req_a=1, we_a=1, addr_a=0x10, wdata_a=0xDEADBEEF -> mem_write high for 1 cycle with mem_address=0x10 and mem_data=0xDEADBEEF; ack_a one cycle, 3 cycles after grant.
REQ-034 Read B after REQ-033: req_b=1, we_b=0, addr_b=0x10 -> ack_b pulse with rdata_b=0xDEADBEEF; rdata_a unchanged; mem_write stays 0.
REQ-035 Conflict, ROUND_ROBIN=1: req_a and req_b held high together from reset for 4 transactions -> grant order A,B,A,B; one ack per 3 cycles.
REQ-036 Conflict, ROUND_ROBIN=0: both held high for 3 transactions -> A,A,A; ack_b never asserted.
REQ-037 Reset mid-write: assert rst_n=0 in the ACCESS cycle of a write to 0x20 -> mem_write=0 next cycle, no ack, all outputs at reset values, busy=0.
REQ-038 Request during busy: raise req_b during A's ACCESS cycle -> B granted on the edge ending ack_a; ack_b follows 3 cycles later.
